// File: rtl/pic_priority_arbiter.sv
// 8259-style interrupt scheduler: IRR/ISR, fixed or rotating priority,
// two-pulse INTA acknowledge and OCW2 EOI/rotate handling.
module pic_priority_arbiter #(
   parameter logic [2:0] SPURIOUS_LVL = 3'd7,
   parameter logic [2:0] RESET_LOWEST = 3'd7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ir,
   input  logic [7:0] mask,
   input  logic       ltim,
   input  logic       aeoi,
   input  logic [4:0] vec_base,
   input  logic       init,
   input  logic       inta_pulse,
   input  logic       ocw2_valid,
   input  logic [2:0] ocw2_cmd,
   input  logic [2:0] ocw2_level,
   output logic       int_out,
   output logic [7:0] vector,
   output logic       vector_valid,
   output logic       spurious,
   output logic [7:0] irr,
   output logic [7:0] isr
);

   typedef enum logic {IDLE, ACK1} state_t;

   state_t     state, state_nx;
   logic [7:0] ir_q, irq_nx;
   logic [7:0] irr_nx, isr_nx, vector_nx;
   logic [7:0] set_bits, clr_bits;
   logic [2:0] lowest_prio, lp_nx;
   logic [2:0] sel, sel_nx;
   logic       rot_aeoi, rot_nx;
   logic       spur_f, spur_nx;
   logic       int_nx, vv_nx, spout_nx;
   logic [3:0] cand, top;
   logic       pend;

   // {found, level} of the highest-ranked set bit
   function automatic logic [3:0] pick(
      input logic [7:0] v,
      input logic [2:0] lp
   );
      logic [3:0] res;
      logic [2:0] idx;
      res = '0;
      for (int k = 7; k >= 0; k--) begin
         idx = lp + 3'd1 + 3'(k);
         if (v[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   function automatic logic [2:0] rank(
      input logic [2:0] l,
      input logic [2:0] lp
   );
      return l - lp - 3'd1;
   endfunction

   assign cand = pick(irr & ~mask, lowest_prio);
   assign top  = pick(isr, lowest_prio);
   assign pend = cand[3] &&
      (isr == 8'd0 ||
       rank(cand[2:0], lowest_prio) < rank(top[2:0], lowest_prio));

   always_comb begin
      state_nx  = state;
      sel_nx    = sel;
      spur_nx   = spur_f;
      lp_nx     = lowest_prio;
      rot_nx    = rot_aeoi;
      vector_nx = vector;
      vv_nx     = 1'b0;
      spout_nx  = 1'b0;
      int_nx    = 1'b0;
      set_bits  = '0;
      clr_bits  = '0;

      unique case (state)
         IDLE: begin
            int_nx = pend;
            if (inta_pulse) begin
               int_nx   = 1'b0;
               state_nx = ACK1;
               if (pend) begin
                  sel_nx   = cand[2:0];
                  set_bits = 8'd1 << cand[2:0];
               end else begin
                  sel_nx  = SPURIOUS_LVL;
                  spur_nx = 1'b1;
               end
            end
         end
         ACK1: begin
            if (inta_pulse) begin
               vector_nx = {vec_base, sel};
               vv_nx     = 1'b1;
               spout_nx  = spur_f;
               spur_nx   = 1'b0;
               state_nx  = IDLE;
               if (aeoi && !spur_f) begin
                  clr_bits = 8'd1 << sel;
                  if (rot_aeoi) lp_nx = sel;
               end
            end
         end
      endcase

      // OCW2 clears use the pre-cycle ISR; its priority write wins
      if (ocw2_valid) begin
         case (ocw2_cmd)
            3'b001: if (top[3]) clr_bits[top[2:0]] = 1'b1;
            3'b011: clr_bits[ocw2_level] = 1'b1;
            3'b101: begin
               if (top[3]) begin
                  clr_bits[top[2:0]] = 1'b1;
                  lp_nx = top[2:0];
               end
            end
            3'b111: begin
               clr_bits[ocw2_level] = 1'b1;
               lp_nx = ocw2_level;
            end
            3'b110: lp_nx  = ocw2_level;
            3'b100: rot_nx = 1'b1;
            3'b000: rot_nx = 1'b0;
            default: ;
         endcase
      end

      isr_nx = (isr & ~clr_bits) | set_bits;
      if (ltim) irr_nx = ir & ~set_bits;
      else irr_nx = (irr | (ir & ~ir_q)) & ir & ~set_bits;
      irq_nx = ir;

      if (init) begin
         state_nx  = IDLE;
         sel_nx    = '0;
         spur_nx   = 1'b0;
         lp_nx     = RESET_LOWEST;
         rot_nx    = 1'b0;
         vector_nx = '0;
         vv_nx     = 1'b0;
         spout_nx  = 1'b0;
         int_nx    = 1'b0;
         isr_nx    = '0;
         irr_nx    = '0;
         irq_nx    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         sel          <= '0;
         spur_f       <= 1'b0;
         lowest_prio  <= RESET_LOWEST;
         rot_aeoi     <= 1'b0;
         vector       <= '0;
         vector_valid <= 1'b0;
         spurious     <= 1'b0;
         int_out      <= 1'b0;
         isr          <= '0;
         irr          <= '0;
         ir_q         <= '0;
      end else begin
         state        <= state_nx;
         sel          <= sel_nx;
         spur_f       <= spur_nx;
         lowest_prio  <= lp_nx;
         rot_aeoi     <= rot_nx;
         vector       <= vector_nx;
         vector_valid <= vv_nx;
         spurious     <= spout_nx;
         int_out      <= int_nx;
         isr          <= isr_nx;
         irr          <= irr_nx;
         ir_q         <= irq_nx;
      end
   end

endmodule

// File: tb/tb_pic_priority_arbiter.sv
// Bench for pic_priority_arbiter: scripted vector table, corner
// sequences, then random traffic against a behavioural model.
module tb_pic_priority_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ir = '0;
   logic [7:0] mask = '0;
   logic       ltim = 1'b0;
   logic       aeoi = 1'b0;
   logic [4:0] vec_base = 5'b01000;
   logic       init = 1'b0;
   logic       inta_pulse = 1'b0;
   logic       ocw2_valid = 1'b0;
   logic [2:0] ocw2_cmd = '0;
   logic [2:0] ocw2_level = '0;
   logic       int_out;
   logic [7:0] vector;
   logic       vector_valid;
   logic       spurious;
   logic [7:0] irr;
   logic [7:0] isr;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   pic_priority_arbiter dut (
      .clk(clk),
      .rst_n(rst_n),
      .ir(ir),
      .mask(mask),
      .ltim(ltim),
      .aeoi(aeoi),
      .vec_base(vec_base),
      .init(init),
      .inta_pulse(inta_pulse),
      .ocw2_valid(ocw2_valid),
      .ocw2_cmd(ocw2_cmd),
      .ocw2_level(ocw2_level),
      .int_out(int_out),
      .vector(vector),
      .vector_valid(vector_valid),
      .spurious(spurious),
      .irr(irr),
      .isr(isr)
   );

   task automatic chk8(string nm, logic [7:0] a, logic [7:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
      end
   endtask

   task automatic chk1(string nm, logic a, logic e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%b want=%b t=%0t", nm, a, e, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0] ir;
      logic       inta;
      logic [3:0] ocw;
      logic [2:0] lvl;
      logic       io;
      logic [7:0] irr_e;
      logic [7:0] isr_e;
      logic [7:0] vec_e;
      logic       vv_e;
   } row_t;

   row_t tbl[$];

   function automatic void add(
      logic [7:0] r_ir, logic r_inta, logic [3:0] r_ocw,
      logic [2:0] r_lvl, logic r_io, logic [7:0] r_irr,
      logic [7:0] r_isr, logic [7:0] r_vec, logic r_vv
   );
      row_t r;
      r.ir = r_ir;
      r.inta = r_inta;
      r.ocw = r_ocw;
      r.lvl = r_lvl;
      r.io = r_io;
      r.irr_e = r_irr;
      r.isr_e = r_isr;
      r.vec_e = r_vec;
      r.vv_e = r_vv;
      tbl.push_back(r);
   endfunction

   // behavioural reference
   bit [7:0] m_irr, m_isr, m_irq, m_vec;
   int       m_lp, m_sel;
   bit       m_rot, m_ack, m_spf, m_io, m_vv, m_sp;

   function automatic void m_reset();
      m_irr = 0; m_isr = 0; m_irq = 0; m_vec = 0;
      m_lp = 7; m_sel = 0;
      m_rot = 0; m_ack = 0; m_spf = 0;
      m_io = 0; m_vv = 0; m_sp = 0;
   endfunction

   function automatic int best(bit [7:0] v, int lp);
      for (int r = 0; r < 8; r++) begin
         int l = (lp + 1 + r) % 8;
         if (v[l]) return l;
      end
      return -1;
   endfunction

   function automatic int rk(int l, int lp);
      return (l - lp - 1 + 16) % 8;
   endfunction

   function automatic void m_step();
      int c, t, lpn;
      bit p;
      bit [7:0] setm, clr;
      if (init) begin
         m_reset();
         return;
      end
      setm = 0;
      clr = 0;
      c = best(m_irr & ~mask, m_lp);
      t = best(m_isr, m_lp);
      p = (c >= 0) && (t < 0 || rk(c, m_lp) < rk(t, m_lp));
      lpn = m_lp;
      m_vv = 0;
      m_sp = 0;
      if (!m_ack) begin
         m_io = p && !inta_pulse;
         if (inta_pulse) begin
            m_ack = 1;
            if (p) begin
               m_sel = c;
               setm[c] = 1;
            end else begin
               m_sel = 7;
               m_spf = 1;
            end
         end
      end else begin
         m_io = 0;
         if (inta_pulse) begin
            m_vec = {vec_base, m_sel[2:0]};
            m_vv = 1;
            m_sp = m_spf;
            if (aeoi && !m_spf) begin
               clr[m_sel] = 1;
               if (m_rot) lpn = m_sel;
            end
            m_spf = 0;
            m_ack = 0;
         end
      end
      if (ocw2_valid) begin
         case (ocw2_cmd)
            3'd1: if (t >= 0) clr[t] = 1;
            3'd3: clr[ocw2_level] = 1;
            3'd5: if (t >= 0) begin clr[t] = 1; lpn = t; end
            3'd7: begin clr[ocw2_level] = 1; lpn = int'(ocw2_level); end
            3'd6: lpn = int'(ocw2_level);
            3'd4: m_rot = 1;
            3'd0: m_rot = 0;
            default: ;
         endcase
      end
      m_isr = (m_isr & ~clr) | setm;
      if (ltim) m_irr = ir & ~setm;
      else m_irr = (m_irr | (ir & ~m_irq)) & ir & ~setm;
      m_irq = ir;
      m_lp = lpn;
   endfunction

   initial begin
      // ir, inta, {v,cmd}, L, int, irr, isr, vector, vv
      add(8'h08,1'b0,4'h0,3'd0,1'b0,8'h08,8'h00,8'h00,1'b0);
      add(8'h08,1'b0,4'h0,3'd0,1'b1,8'h08,8'h00,8'h00,1'b0);
      add(8'h08,1'b1,4'h0,3'd0,1'b0,8'h00,8'h08,8'h00,1'b0);
      add(8'h08,1'b0,4'h0,3'd0,1'b0,8'h00,8'h08,8'h00,1'b0);
      add(8'h08,1'b1,4'h0,3'd0,1'b0,8'h00,8'h08,8'h43,1'b1);
      add(8'h08,1'b0,4'h0,3'd0,1'b0,8'h00,8'h08,8'h43,1'b0);
      add(8'h00,1'b0,4'h9,3'd0,1'b0,8'h00,8'h00,8'h43,1'b0);
      add(8'h24,1'b0,4'h0,3'd0,1'b0,8'h24,8'h00,8'h43,1'b0);
      add(8'h24,1'b0,4'h0,3'd0,1'b1,8'h24,8'h00,8'h43,1'b0);
      add(8'h24,1'b1,4'h0,3'd0,1'b0,8'h20,8'h04,8'h43,1'b0);
      add(8'h24,1'b1,4'h0,3'd0,1'b0,8'h20,8'h04,8'h42,1'b1);
      add(8'h24,1'b0,4'h9,3'd0,1'b0,8'h20,8'h00,8'h42,1'b0);
      add(8'h24,1'b0,4'h0,3'd0,1'b1,8'h20,8'h00,8'h42,1'b0);
      add(8'h24,1'b1,4'h0,3'd0,1'b0,8'h00,8'h20,8'h42,1'b0);
      add(8'h24,1'b1,4'h0,3'd0,1'b0,8'h00,8'h20,8'h45,1'b1);
      add(8'h00,1'b0,4'h9,3'd0,1'b0,8'h00,8'h00,8'h45,1'b0);
      add(8'h10,1'b0,4'h0,3'd0,1'b0,8'h10,8'h00,8'h45,1'b0);
      add(8'h10,1'b0,4'h0,3'd0,1'b1,8'h10,8'h00,8'h45,1'b0);
      add(8'h10,1'b1,4'h0,3'd0,1'b0,8'h00,8'h10,8'h45,1'b0);
      add(8'h10,1'b1,4'h0,3'd0,1'b0,8'h00,8'h10,8'h44,1'b1);
      add(8'h50,1'b0,4'h0,3'd0,1'b0,8'h40,8'h10,8'h44,1'b0);
      add(8'h50,1'b0,4'h0,3'd0,1'b0,8'h40,8'h10,8'h44,1'b0);
      add(8'h52,1'b0,4'h0,3'd0,1'b0,8'h42,8'h10,8'h44,1'b0);
      add(8'h52,1'b0,4'h0,3'd0,1'b1,8'h42,8'h10,8'h44,1'b0);
      add(8'h52,1'b1,4'h0,3'd0,1'b0,8'h40,8'h12,8'h44,1'b0);
      add(8'h52,1'b1,4'h0,3'd0,1'b0,8'h40,8'h12,8'h41,1'b1);
      add(8'h00,1'b0,4'h9,3'd0,1'b0,8'h00,8'h10,8'h41,1'b0);
      add(8'h00,1'b0,4'h9,3'd0,1'b0,8'h00,8'h00,8'h41,1'b0);
      add(8'h08,1'b0,4'h0,3'd0,1'b0,8'h08,8'h00,8'h41,1'b0);
      add(8'h08,1'b0,4'h0,3'd0,1'b1,8'h08,8'h00,8'h41,1'b0);
      add(8'h08,1'b1,4'h0,3'd0,1'b0,8'h00,8'h08,8'h41,1'b0);
      add(8'h08,1'b1,4'h0,3'd0,1'b0,8'h00,8'h08,8'h43,1'b1);
      add(8'h00,1'b0,4'hD,3'd0,1'b0,8'h00,8'h00,8'h43,1'b0);
      add(8'h14,1'b0,4'h0,3'd0,1'b0,8'h14,8'h00,8'h43,1'b0);
      add(8'h14,1'b0,4'h0,3'd0,1'b1,8'h14,8'h00,8'h43,1'b0);
      add(8'h14,1'b1,4'h0,3'd0,1'b0,8'h04,8'h10,8'h43,1'b0);
      add(8'h14,1'b1,4'h0,3'd0,1'b0,8'h04,8'h10,8'h44,1'b1);
      add(8'h14,1'b0,4'hE,3'd7,1'b0,8'h04,8'h10,8'h44,1'b0);
      add(8'h14,1'b0,4'h0,3'd0,1'b1,8'h04,8'h10,8'h44,1'b0);
      add(8'h00,1'b0,4'hB,3'd4,1'b1,8'h00,8'h00,8'h44,1'b0);
      add(8'h00,1'b0,4'h0,3'd0,1'b0,8'h00,8'h00,8'h44,1'b0);

      // reset state
      cyc();
      cyc();
      chk1("rst_int", int_out, 1'b0);
      chk8("rst_irr", irr, 8'h00);
      chk8("rst_isr", isr, 8'h00);
      chk8("rst_vec", vector, 8'h00);
      chk1("rst_vv", vector_valid, 1'b0);
      chk1("rst_sp", spurious, 1'b0);
      rst_n = 1'b1;
      cyc();

      for (int i = 0; i < tbl.size(); i++) begin
         ir = tbl[i].ir;
         inta_pulse = tbl[i].inta;
         ocw2_valid = tbl[i].ocw[3];
         ocw2_cmd = tbl[i].ocw[2:0];
         ocw2_level = tbl[i].lvl;
         cyc();
         chk1($sformatf("t%0d_int", i), int_out, tbl[i].io);
         chk8($sformatf("t%0d_irr", i), irr, tbl[i].irr_e);
         chk8($sformatf("t%0d_isr", i), isr, tbl[i].isr_e);
         chk8($sformatf("t%0d_vec", i), vector, tbl[i].vec_e);
         chk1($sformatf("t%0d_vv", i), vector_valid, tbl[i].vv_e);
      end
      inta_pulse = 1'b0;
      ocw2_valid = 1'b0;

      // AEOI acknowledge of IR0
      aeoi = 1'b1;
      ir = 8'h01;
      cyc();
      cyc();
      chk1("aeoi_int", int_out, 1'b1);
      inta_pulse = 1'b1;
      cyc();
      chk8("aeoi_isr1", isr, 8'h01);
      cyc();
      chk8("aeoi_vec", vector, 8'h40);
      chk1("aeoi_vv", vector_valid, 1'b1);
      chk1("aeoi_sp", spurious, 1'b0);
      chk8("aeoi_isr2", isr, 8'h00);
      inta_pulse = 1'b0;
      ir = 8'h00;
      aeoi = 1'b0;
      cyc();

      // spurious pair with IR7 in service under AEOI
      ir = 8'h80;
      cyc();
      cyc();
      inta_pulse = 1'b1;
      cyc();
      cyc();
      inta_pulse = 1'b0;
      ir = 8'h00;
      chk8("ir7_isr", isr, 8'h80);
      aeoi = 1'b1;
      cyc();
      chk1("sp_int", int_out, 1'b0);
      inta_pulse = 1'b1;
      cyc();
      chk1("sp_vv1", vector_valid, 1'b0);
      cyc();
      chk8("sp_vec", vector, 8'h47);
      chk1("sp_vv2", vector_valid, 1'b1);
      chk1("sp_flag", spurious, 1'b1);
      chk8("sp_isr", isr, 8'h80);
      inta_pulse = 1'b0;
      aeoi = 1'b0;
      ocw2_valid = 1'b1;
      ocw2_cmd = 3'b001;
      cyc();
      ocw2_valid = 1'b0;
      chk8("sp_eoi", isr, 8'h00);
      chk1("sp_vv3", vector_valid, 1'b0);

      // asynchronous reset while in ACK1
      ir = 8'h08;
      cyc();
      cyc();
      inta_pulse = 1'b1;
      cyc();
      inta_pulse = 1'b0;
      ir = 8'h00;
      chk8("ar_isr0", isr, 8'h08);
      #2 rst_n = 1'b0;
      #1;
      chk8("ar_isr", isr, 8'h00);
      chk1("ar_int", int_out, 1'b0);
      cyc();
      rst_n = 1'b1;
      cyc();
      inta_pulse = 1'b1;
      cyc();
      chk1("ar_vv1", vector_valid, 1'b0);
      cyc();
      chk1("ar_vv2", vector_valid, 1'b1);
      chk1("ar_sp", spurious, 1'b1);
      inta_pulse = 1'b0;
      cyc();

      // init pulse while in ACK1
      ir = 8'h08;
      cyc();
      cyc();
      inta_pulse = 1'b1;
      cyc();
      inta_pulse = 1'b0;
      ir = 8'h00;
      chk8("in_isr0", isr, 8'h08);
      init = 1'b1;
      cyc();
      init = 1'b0;
      chk8("in_isr", isr, 8'h00);
      chk8("in_irr", irr, 8'h00);
      chk1("in_int", int_out, 1'b0);
      inta_pulse = 1'b1;
      cyc();
      chk1("in_vv1", vector_valid, 1'b0);
      cyc();
      chk1("in_vv2", vector_valid, 1'b1);
      chk1("in_sp", spurious, 1'b1);
      inta_pulse = 1'b0;
      cyc();

      // random traffic against the model
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      m_reset();
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            int k = $urandom_range(0, 7);
            ir[k] = ~ir[k];
         end
         if ($urandom_range(0, 63) == 0)
            mask = 8'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 299) == 0) ltim = ~ltim;
         if ($urandom_range(0, 149) == 0) aeoi = ~aeoi;
         if ($urandom_range(0, 499) == 0) vec_base = 5'($urandom);
         inta_pulse = ($urandom_range(0, 3) == 0);
         ocw2_valid = ($urandom_range(0, 7) == 0);
         ocw2_cmd = 3'($urandom);
         ocw2_level = 3'($urandom);
         init = ($urandom_range(0, 299) == 0);
         m_step();
         cyc();
         chk1("r_int", int_out, m_io);
         chk8("r_irr", irr, m_irr);
         chk8("r_isr", isr, m_isr);
         chk8("r_vec", vector, m_vec);
         chk1("r_vv", vector_valid, m_vv);
         chk1("r_sp", spurious, m_sp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pic_priority_arbiter.md
Name: pic_priority_arbiter

Overview:
- Clocked interrupt scheduler for the 8259-style PIC. It shares the single CPU INT line among eight IR requesters.
- Holds the IRR and ISR and resolves priority, using fixed or rotating order.
- Sequences the two-pulse INTA acknowledge and returns the vector {vec_base, level}.
- Executes OCW2 EOI and rotate commands. The control-logic block supplies mask, AEOI, LTIM, vector base, decoded OCW2 fields and synchronised INTA pulses.

Parameters:
- SPURIOUS_LVL, 7: level reported in the vector when INTA arrives with no valid candidate.
- RESET_LOWEST, 7: reset and init value of the lowest-priority pointer, so IR0 is highest.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ir  in  8  raw interrupt request lines, already synchronised.
- mask  in  8  IMR; 1 = masked.
- ltim  in  1  1 = level-triggered, 0 = edge-triggered.
- aeoi  in  1  automatic EOI enable.
- vec_base  in  5  vector bits [7:3].
- init  in  1  one-cycle pulse on an ICW1 write.
- inta_pulse  in  1  one-cycle pulse per INTA falling edge.
- ocw2_valid  in  1  one-cycle strobe; OCW2 fields are valid.
- ocw2_cmd  in  3  {R, SL, EOI}.
- ocw2_level  in  3  L2..L0.
- int_out  out  1  interrupt request to the CPU.
- vector  out  8  acknowledge vector.
- vector_valid  out  1  one-cycle pulse; vector valid.
- spurious  out  1  high with vector_valid when the acknowledge was spurious.
- irr  out  8  interrupt request register.
- isr  out  8  in-service register.

Behaviour:
- Reset (rst_n=0, asynchronous), all registers cleared except lowest_prio:
  - irr=0, isr=0, ir_q=0, int_out=0, vector=0, vector_valid=0, spurious=0.
  - lowest_prio=RESET_LOWEST, rot_aeoi=0, state=IDLE.
- init pulse: same effect as reset, applied synchronously. It aborts any acknowledge in progress.
- IRR, edge mode (ltim=0):
  - irr[i] sets on an ir[i] 0->1 transition (ir & ~ir_q).
  - It clears when level i is selected at ACK1 entry, or when ir[i] falls before acknowledge.
- IRR, level mode (ltim=1): irr[i] = ir[i] each cycle, but a selected bit is forced 0 for the cycle it is acknowledged.
- Priority: rank(i) = (i - lowest_prio - 1) mod 8, 3-bit wrap; rank 0 is highest.
- Candidate c: the minimum-rank bit of irr & ~mask.
- Top in-service t: the minimum-rank bit of isr.
- pend = candidate exists AND (isr==0 OR rank(c) < rank(t)). This is fully nested: an equal or lower level never interrupts.
- FSM states: IDLE, ACK1.
- IDLE:
  - int_out is registered and equals pend of the previous cycle.
  - On inta_pulse with pend=1: sel<=c, isr[c]<=1, clear irr[c], int_out<=0, go to ACK1.
  - On inta_pulse with pend=0: sel<=SPURIOUS_LVL, spur_f<=1, ISR unchanged, go to ACK1.
- ACK1:
  - int_out=0.
  - sel is frozen; mask or ir changes do not alter it.
  - On inta_pulse:
    - vector<={vec_base, sel}, vector_valid=1 for one cycle, spurious=spur_f.
    - If aeoi and not spurious: clear isr[sel]; if rot_aeoi also set, lowest_prio<=sel.
    - Clear spur_f and return to IDLE.
  - vector holds its value until the next acknowledge.
- Minimum latency: ir rise at cycle n sets irr at n+1; int_out asserts at n+2.
- OCW2 decode on ocw2_valid:
  - 001: non-specific EOI; clear isr[t]; no-op if isr==0.
  - 011: specific EOI; clear isr[L].
  - 101: rotate on non-specific EOI; clear isr[t] and set lowest_prio<=t; no-op if isr==0.
  - 111: rotate on specific EOI; clear isr[L] and set lowest_prio<=L.
  - 110: set priority; lowest_prio<=L.
  - 100: rot_aeoi<=1.
  - 000: rot_aeoi<=0.
  - 010: no-op.
- Simultaneous ocw2_valid and inta_pulse in one cycle:
  - OCW2 clears are computed from the pre-cycle ISR; the INTA set is applied afterwards, so a set on the same bit wins.
  - An OCW2 priority update and an AEOI rotate in the same cycle: the OCW2 value wins.
  - Candidate selection uses the pre-update lowest_prio.
- Masking a bit during ACK1 has no effect on the vector; the ISR bit stays set until EOI.

Test Plan:
- Basic acknowledge: vec_base=5'b01000, ir[3] rises, mask=0 → int_out=1 two cycles later. INTA#1 → isr=8'h08, irr[3]=0. INTA#2 → vector=8'h43, vector_valid for one cycle.
- Fixed priority: ir[5] and ir[2] rise together → vector level 2 first. After non-specific EOI (001) and a second INTA pair → level 5, then isr=8'h20.
- Nesting: isr=8'h10 with ir[6] pending → int_out stays 0. ir[1] rises → int_out=1; after INTA#1, isr=8'h12.
- Rotation: isr=8'h08, then OCW2 101 → isr=0, lowest_prio=3. ir[2] and ir[4] both pending → level 4 acknowledged first.
- AEOI and spurious: aeoi=1, ir[0] acknowledged → isr=0 after INTA#2. A separate INTA pair with no request → vector={vec_base,3'd7}, spurious=1, isr unchanged.
- Reset and init mid-sequence: assert rst_n=0 or pulse init while in ACK1 → state=IDLE, isr=0, int_out=0, and no vector_valid on the subsequent INTA.
